rv32imf_prefetch_ctrl: RTL and testbench

// Sequences word-aligned instruction fetches on the OBI-style instruction bus and

---
 rtl/rv32imf_prefetch_ctrl.sv | 126 ++++++++++++
 tb/tb_rv32imf_prefetch_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rv32imf_prefetch_ctrl.sv
// Instruction-fetch sequencer: issues word-aligned OBI requests, throttles on FIFO space and
// outstanding count, and on a redirect flushes the FIFO and drops responses already in flight.
module rv32imf_prefetch_ctrl #(
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned FW = $clog2(DEPTH + 1),
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic          branch_i,
  input  logic [31:0]   branch_addr_i,
  output logic          busy_o,
  output logic          instr_req_o,
  input  logic          instr_gnt_i,
  output logic [31:0]   instr_addr_o,
  input  logic          instr_rvalid_i,
  input  logic [FW-1:0] fifo_cnt_i,
  output logic          fifo_push_o,
  output logic          fifo_flush_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, BRANCH_WAIT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   trans_addr_q, trans_addr_d;
  logic [31:0]   saved_addr_q, saved_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;

  logic [31:0] target, cnt_ext, fifo_ext;
  logic        slot_ok, req_raw, acc;
  logic        unused_addr_lsb;

  assign target          = {branch_addr_i[31:2], 2'b00};
  assign unused_addr_lsb = ^branch_addr_i[1:0];

  assign cnt_ext  = 32'(cnt_q);
  assign fifo_ext = 32'(fifo_cnt_i);
  assign slot_ok  = (cnt_ext < MAX_OUTSTANDING) && ((cnt_ext + fifo_ext) < DEPTH);

  // Once a request is raised it must stay up until granted, regardless of req_i or a branch.
  always_comb begin
    req_raw = 1'b1;
    if (state_q == IDLE) req_raw = req_i && slot_ok && !branch_i;
  end

  // Outputs are forced low while reset is asserted so nothing leaks onto the bus or FIFO.
  assign instr_req_o  = rst_n && req_raw;
  assign instr_addr_o = trans_addr_q;
  assign fifo_push_o  = rst_n && instr_rvalid_i && !branch_i && (flush_cnt_q == '0);
  assign fifo_flush_o = rst_n && branch_i;
  assign busy_o       = (state_q != IDLE) || (cnt_q != '0);

  assign acc = instr_req_o && instr_gnt_i;

  always_comb begin
    state_d      = state_q;
    trans_addr_d = trans_addr_q;
    saved_addr_d = saved_addr_q;
    case (state_q)
      IDLE: begin
        if (branch_i) trans_addr_d = target;
        else if (instr_req_o) begin
          if (instr_gnt_i) trans_addr_d = trans_addr_q + 32'd4;
          else             state_d      = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (branch_i) begin
          saved_addr_d = target;
          if (instr_gnt_i) begin
            state_d      = IDLE;
            trans_addr_d = target;
          end else begin
            state_d = BRANCH_WAIT;
          end
        end else if (instr_gnt_i) begin
          state_d      = IDLE;
          trans_addr_d = trans_addr_q + 32'd4;
        end
      end
      BRANCH_WAIT: begin
        if (branch_i) saved_addr_d = target;
        if (instr_gnt_i) begin
          state_d      = IDLE;
          trans_addr_d = branch_i ? target : saved_addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CW'(acc) - CW'(instr_rvalid_i);
    // A redirect condemns everything in flight, including a grant landing this very cycle.
    if (branch_i) begin
      flush_cnt_d = cnt_q + CW'(acc) - CW'(instr_rvalid_i);
    end else begin
      flush_cnt_d = flush_cnt_q;
      if (instr_rvalid_i && (flush_cnt_q != '0)) flush_cnt_d = flush_cnt_d - CW'(1);
      if ((state_q == BRANCH_WAIT) && acc)       flush_cnt_d = flush_cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      trans_addr_q <= '0;
      saved_addr_q <= '0;
      cnt_q        <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      trans_addr_q <= trans_addr_d;
      saved_addr_q <= saved_addr_d;
      cnt_q        <= cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(instr_rvalid_i && (cnt_q == '0)));

endmodule

// File: tb/tb_rv32imf_prefetch_ctrl.sv
// Directed bench for the prefetch controller: each granted request queues whether its response
// should reach the FIFO; responses pop the queue and are compared against fifo_push_o.
module tb_rv32imf_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0, branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        busy_o, instr_req_o, instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic [1:0]  fifo_cnt_i = '0;
  logic        fifo_push_o, fifo_flush_o;

  int n_chk = 0, n_pass = 0;
  bit sb[$];

  rv32imf_prefetch_ctrl #(.DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .busy_o(busy_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i), .fifo_cnt_i(fifo_cnt_i),
    .fifo_push_o(fifo_push_o), .fifo_flush_o(fifo_flush_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set(input logic r, input logic g, input logic v, input logic b,
                     input logic [31:0] a);
    req_i = r; instr_gnt_i = g; instr_rvalid_i = v; branch_i = b; branch_addr_i = a;
    #1;
  endtask

  // Score this cycle's response/grant, then advance one clock.
  task automatic tick(input bit keep);
    bit e;
    check("flush", 32'(fifo_flush_o), 32'(branch_i));
    if (instr_rvalid_i) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        check("push", 32'(fifo_push_o), branch_i ? 32'd0 : 32'(e));
      end
    end else check("push_idle", 32'(fifo_push_o), 32'd0);
    if (branch_i) foreach (sb[i]) sb[i] = 1'b0;
    if (instr_req_o && instr_gnt_i) sb.push_back(branch_i ? 1'b0 : keep);
    @(posedge clk); #1;
  endtask

  initial begin
    req_i = 1'b1; #2;
    check("rst_req", 32'(instr_req_o), 0);
    check("rst_addr", instr_addr_o, 0);
    check("rst_busy", 32'(busy_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: back-to-back fetch with single-cycle response latency
    set(1,1,0,0,0); check("s1_req", 32'(instr_req_o), 1); check("s1_a0", instr_addr_o, 32'h0); tick(1);
    set(1,1,1,0,0); check("s1_a1", instr_addr_o, 32'h4); tick(1);
    set(1,1,1,0,0); check("s1_a2", instr_addr_o, 32'h8); tick(1);
    set(0,0,1,0,0); check("s1_noreq", 32'(instr_req_o), 0); tick(1);
    set(0,0,0,0,0); check("s1_idle", 32'(busy_o), 0); check("s1_next", instr_addr_o, 32'hC); tick(1);

    // 2: FIFO space throttling
    fifo_cnt_i = 2;
    set(1,0,0,0,0); check("s2_full", 32'(instr_req_o), 0); tick(1);
    fifo_cnt_i = 1;
    set(1,1,0,0,0); check("s2_room", 32'(instr_req_o), 1); check("s2_a", instr_addr_o, 32'hC); tick(1);
    set(1,0,1,0,0); check("s2_cnt_fifo", 32'(instr_req_o), 0); tick(1);
    fifo_cnt_i = 0;
    set(0,0,0,0,0); tick(1);

    // 3: branch with two responses outstanding
    set(1,1,0,0,0); check("s3_a0", instr_addr_o, 32'h10); tick(1);
    set(1,1,0,0,0); check("s3_a1", instr_addr_o, 32'h14); tick(1);
    set(1,1,0,1,32'h102); check("s3_br_noreq", 32'(instr_req_o), 0); tick(1);
    set(1,1,1,0,0); check("s3_max_out", 32'(instr_req_o), 0); tick(1);
    set(1,1,1,0,0); check("s3_req", 32'(instr_req_o), 1); check("s3_tgt", instr_addr_o, 32'h100); tick(1);
    set(0,0,1,0,0); tick(1);

    // 4: branch while waiting for grant
    set(1,0,0,0,0); check("s4_a", instr_addr_o, 32'h104); tick(1);
    set(1,0,0,1,32'h200); check("s4_hold_req", 32'(instr_req_o), 1);
    check("s4_hold_a", instr_addr_o, 32'h104); check("s4_busy", 32'(busy_o), 1); tick(1);
    set(0,0,0,0,0); check("s4_bw_req", 32'(instr_req_o), 1); check("s4_bw_a", instr_addr_o, 32'h104); tick(1);
    set(1,1,0,0,0); check("s4_gnt_a", instr_addr_o, 32'h104); tick(0);
    set(1,1,1,0,0); check("s4_tgt", instr_addr_o, 32'h200); tick(1);
    set(0,0,1,0,0); tick(1);

    // 5: branch, response and grant in the same cycle
    set(1,1,0,0,0); check("s5_a0", instr_addr_o, 32'h204); tick(1);
    set(1,0,0,0,0); check("s5_a1", instr_addr_o, 32'h208); tick(1);
    set(1,1,1,1,32'h300); check("s5_req", 32'(instr_req_o), 1); tick(1);
    set(1,1,1,0,0); check("s5_tgt", instr_addr_o, 32'h300); tick(1);
    set(0,0,1,0,0); tick(1);

    // 6: reset with two requests outstanding
    set(1,1,0,0,0); check("s6_a0", instr_addr_o, 32'h304); tick(1);
    set(1,1,0,0,0); check("s6_a1", instr_addr_o, 32'h308); tick(1);
    set(1,0,0,1,32'h400);
    rst_n = 1'b0; #1;
    check("s6_req", 32'(instr_req_o), 0);
    check("s6_addr", instr_addr_o, 0);
    check("s6_busy", 32'(busy_o), 0);
    check("s6_push", 32'(fifo_push_o), 0);
    check("s6_flush", 32'(fifo_flush_o), 0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    set(1,1,0,0,0); check("s6_restart", 32'(instr_req_o), 1); check("s6_a", instr_addr_o, 32'h0); tick(1);
    set(0,0,1,0,0); tick(1);
    set(0,0,0,0,0); check("s6_idle", 32'(busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
